// File: rtl/framing_pkg.sv
// Shared framing definitions: deframer state encoding, default tail bytes
// and the ceil-div helper used to size frames in bytes.
package framing_pkg;

    typedef enum logic [1:0] {
        PAYLOAD = 2'd0,
        TAIL0   = 2'd1,
        TAIL1   = 2'd2,
        RESYNC  = 2'd3
    } tail_deframer_state_e;

    localparam logic [7:0] TAIL_BYTE0_DEFAULT = 8'hA5;
    localparam logic [7:0] TAIL_BYTE1_DEFAULT = 8'h5A;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/byte_unpacker.sv
// Holds one packed byte and emits its elements LSB first, refilling in the
// same cycle the last element of the byte is consumed.
module byte_unpacker #(
    parameter int unsigned UnpackedWidth = 1,
    parameter int unsigned PackedNum     = 8,
    parameter int unsigned LastElems     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     final_byte_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [UnpackedWidth-1:0] unpacked_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     load_o,
    output logic                     frame_done_o
);

    localparam int unsigned ElemW = $clog2(PackedNum + 1);

    logic [7:0]       hold_r;
    logic             hold_valid_r;
    logic             hold_final_r;
    logic             last_r;
    logic [ElemW-1:0] elem_left_r;

    logic             beat_s;
    logic             byte_end_s;
    logic             frame_done_s;
    logic             ready_s;
    logic             load_s;
    logic [ElemW-1:0] load_left_s;

    assign beat_s       = hold_valid_r && ready_i;
    assign byte_end_s   = beat_s && (elem_left_r == ElemW'(1));
    assign frame_done_s = beat_s && last_r;
    assign ready_s      = enable_i && (!hold_valid_r || byte_end_s);
    // A byte offered as the frame's last element leaves belongs to the tail, not the hold register.
    assign load_s       = ready_s && valid_i && !frame_done_s;
    assign load_left_s  = final_byte_i ? ElemW'(LastElems) : ElemW'(PackedNum);

    // Hold register, element countdown and last-element flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_r       <= 8'h00;
            hold_valid_r <= 1'b0;
            hold_final_r <= 1'b0;
            last_r       <= 1'b0;
            elem_left_r  <= '0;
        end else if (load_s) begin
            hold_r       <= data_i;
            hold_valid_r <= 1'b1;
            hold_final_r <= final_byte_i;
            last_r       <= final_byte_i && (load_left_s == ElemW'(1));
            elem_left_r  <= load_left_s;
        end else if (beat_s) begin
            hold_r       <= hold_r >> UnpackedWidth;
            hold_valid_r <= (elem_left_r != ElemW'(1));
            hold_final_r <= hold_final_r;
            last_r       <= hold_final_r && (elem_left_r == ElemW'(2));
            elem_left_r  <= elem_left_r - ElemW'(1);
        end else begin
            hold_r       <= hold_r;
            hold_valid_r <= hold_valid_r;
            hold_final_r <= hold_final_r;
            last_r       <= last_r;
            elem_left_r  <= elem_left_r;
        end
    end

    assign ready_o      = ready_s;
    assign unpacked_o   = hold_r[UnpackedWidth-1:0];
    assign valid_o      = hold_valid_r;
    assign last_o       = last_r;
    assign load_o       = load_s;
    assign frame_done_o = frame_done_s;

endmodule

// File: rtl/tail_deframer.sv
// Receive-side deframer: unpacks a fixed-length payload, checks the two
// tail bytes and hunts for the tail sequence again after a mismatch.
module tail_deframer
    import framing_pkg::*;
#(
    parameter int unsigned UnpackedWidth  = 1,
    parameter int unsigned PackedNum      = 8,
    parameter int unsigned PacketLenElems = 75684,
    parameter logic [7:0]  TailByte0      = TAIL_BYTE0_DEFAULT,
    parameter logic [7:0]  TailByte1      = TAIL_BYTE1_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [UnpackedWidth-1:0] unpacked_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     frame_ok_o,
    output logic                     tail_err_o
);

    localparam int unsigned PacketBytes = ceil_div(PacketLenElems, PackedNum);
    localparam int unsigned LastElems   = PacketLenElems - (PacketBytes - 1) * PackedNum;
    localparam int unsigned CntW        = $clog2(PacketBytes + 1);

    tail_deframer_state_e state_r, state_next_s;
    logic [CntW-1:0]      byte_cnt_r, byte_cnt_next_s;
    logic                 seen_r, seen_next_s;
    logic                 frame_ok_r, frame_ok_next_s;
    logic                 tail_err_r, tail_err_next_s;

    logic                 final_byte_s;
    logic                 unp_ready_s;
    logic                 unp_load_s;
    logic                 frame_done_s;

    assign final_byte_s = (byte_cnt_r == CntW'(PacketBytes - 1));

    byte_unpacker #(
        .UnpackedWidth(UnpackedWidth),
        .PackedNum    (PackedNum),
        .LastElems    (LastElems)
    ) u_unpacker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (state_r == PAYLOAD),
        .final_byte_i(final_byte_s),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (unp_ready_s),
        .unpacked_o  (unpacked_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .load_o      (unp_load_s),
        .frame_done_o(frame_done_s)
    );

    // Next-state, byte counter and tail-check pulse decisions.
    always_comb begin
        state_next_s    = state_r;
        byte_cnt_next_s = byte_cnt_r;
        seen_next_s     = seen_r;
        frame_ok_next_s = 1'b0;
        tail_err_next_s = 1'b0;
        case (state_r)
            PAYLOAD: begin
                if (unp_load_s) begin
                    byte_cnt_next_s = final_byte_s ? CntW'(0) : byte_cnt_r + CntW'(1);
                end else begin
                    byte_cnt_next_s = byte_cnt_r;
                end
                // The byte arriving alongside the final element is already TailByte0.
                if (frame_done_s && valid_i) begin
                    if (data_i == TailByte0) begin
                        state_next_s = TAIL1;
                    end else begin
                        state_next_s    = RESYNC;
                        seen_next_s     = 1'b0;
                        tail_err_next_s = 1'b1;
                    end
                end else if (frame_done_s) begin
                    state_next_s = TAIL0;
                end else begin
                    state_next_s = PAYLOAD;
                end
            end
            TAIL0: begin
                if (valid_i && (data_i == TailByte0)) begin
                    state_next_s = TAIL1;
                end else if (valid_i) begin
                    state_next_s    = RESYNC;
                    seen_next_s     = 1'b0;
                    tail_err_next_s = 1'b1;
                end else begin
                    state_next_s = TAIL0;
                end
            end
            TAIL1: begin
                if (valid_i && (data_i == TailByte1)) begin
                    state_next_s    = PAYLOAD;
                    frame_ok_next_s = 1'b1;
                end else if (valid_i) begin
                    state_next_s    = RESYNC;
                    seen_next_s     = (data_i == TailByte0);
                    tail_err_next_s = 1'b1;
                end else begin
                    state_next_s = TAIL1;
                end
            end
            RESYNC: begin
                if (valid_i && (data_i == TailByte0)) begin
                    seen_next_s = 1'b1;
                end else if (valid_i && (data_i == TailByte1) && seen_r) begin
                    state_next_s = PAYLOAD;
                    seen_next_s  = 1'b0;
                end else if (valid_i) begin
                    seen_next_s = 1'b0;
                end else begin
                    seen_next_s = seen_r;
                end
            end
            default: begin
                state_next_s    = PAYLOAD;
                byte_cnt_next_s = CntW'(0);
                seen_next_s     = 1'b0;
            end
        endcase
    end

    // State, counter and registered pulse outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= PAYLOAD;
            byte_cnt_r <= '0;
            seen_r     <= 1'b0;
            frame_ok_r <= 1'b0;
            tail_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            byte_cnt_r <= byte_cnt_next_s;
            seen_r     <= seen_next_s;
            frame_ok_r <= frame_ok_next_s;
            tail_err_r <= tail_err_next_s;
        end
    end

    assign ready_o    = (state_r == PAYLOAD) ? unp_ready_s : 1'b1;
    assign frame_ok_o = frame_ok_r;
    assign tail_err_o = tail_err_r;

endmodule

// File: tb/tb_tail_deframer.sv
// Directed bench for tail_deframer: a 1-bit/12-element instance for framing,
// stalls, resync and reset, plus an 8-bit/4-element instance for streaming.
module tb_tail_deframer;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_data_i;
    logic       a_valid_i, a_ready_o, a_unpacked_o, a_valid_o, a_ready_i;
    logic       a_last_o, a_frame_ok_o, a_tail_err_o;

    logic [7:0] b_data_i, b_unpacked_o;
    logic       b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    logic       b_last_o, b_frame_ok_o, b_tail_err_o;

    int         n_checks = 0;
    int         n_errors = 0;

    logic [7:0]  src_q[$];
    logic [31:0] elem_bits, last_bits;
    int          n_elem, n_ok, n_err;

    tail_deframer #(
        .UnpackedWidth(1), .PackedNum(8), .PacketLenElems(12),
        .TailByte0(8'hA5), .TailByte1(8'h5A)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .data_i(a_data_i), .valid_i(a_valid_i),
        .ready_o(a_ready_o), .unpacked_o(a_unpacked_o), .valid_o(a_valid_o),
        .ready_i(a_ready_i), .last_o(a_last_o), .frame_ok_o(a_frame_ok_o),
        .tail_err_o(a_tail_err_o)
    );

    tail_deframer #(
        .UnpackedWidth(8), .PackedNum(1), .PacketLenElems(4),
        .TailByte0(8'hA5), .TailByte1(8'h5A)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .data_i(b_data_i), .valid_i(b_valid_i),
        .ready_o(b_ready_o), .unpacked_o(b_unpacked_o), .valid_o(b_valid_o),
        .ready_i(b_ready_i), .last_o(b_last_o), .frame_ok_o(b_frame_ok_o),
        .tail_err_o(b_tail_err_o)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        elem_bits = 32'h0;
        last_bits = 32'h0;
        n_elem    = 0;
        n_ok      = 0;
        n_err     = 0;
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        src_q.push_back(b0);
        src_q.push_back(b1);
        src_q.push_back(b2);
        src_q.push_back(b3);
    endtask

    // Streams src_q into instance A, records elements and pulses, checks stall stability.
    task automatic run_a(input bit rand_ready, input int stop_elems, input int max_cycles);
        int   cyc;
        int   idle;
        bit   stalled;
        logic held_bit;
        cyc     = 0;
        idle    = 0;
        stalled = 1'b0;
        held_bit = 1'b0;
        while (cyc < max_cycles && idle < 6) begin
            @(negedge clk);
            a_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src_q.size() > 0) begin
                a_valid_i = 1'b1;
                a_data_i  = src_q[0];
            end else begin
                a_valid_i = 1'b0;
                a_data_i  = 8'h00;
            end
            #1;
            if (stalled) begin
                check_eq("stall_valid", 32'(a_valid_o), 32'd1);
                check_eq("stall_data", 32'(a_unpacked_o), 32'(held_bit));
            end
            if (a_frame_ok_o) n_ok++;
            if (a_tail_err_o) n_err++;
            if (a_valid_o && a_ready_i && n_elem < 32) begin
                elem_bits[n_elem] = a_unpacked_o;
                last_bits[n_elem] = a_last_o;
                n_elem++;
            end
            stalled  = a_valid_o && !a_ready_i;
            held_bit = a_unpacked_o;
            if (a_valid_i && a_ready_o) void'(src_q.pop_front());
            if (src_q.size() == 0) idle++;
            cyc++;
            if (stop_elems > 0 && n_elem >= stop_elems) break;
        end
        if (stop_elems == 0) check_eq("src_drained", 32'(src_q.size()), 32'd0);
    endtask

    task automatic expect_obs(input string tag, input int exp_n, input logic [31:0] exp_bits,
                              input logic [31:0] exp_last, input int exp_ok, input int exp_err);
        check_eq({tag, "_count"}, 32'(n_elem), 32'(exp_n));
        check_eq({tag, "_elems"}, elem_bits, exp_bits);
        check_eq({tag, "_last"}, last_bits, exp_last);
        check_eq({tag, "_frame_ok"}, 32'(n_ok), 32'(exp_ok));
        check_eq({tag, "_tail_err"}, 32'(n_err), 32'(exp_err));
    endtask

    initial begin
        int b_n, b_first, b_lastcyc, b_stall, b_ok, b_err;
        logic [31:0] b_elems;
        logic [3:0]  b_lasts;
        logic [7:0]  b_q[$];

        rst_n     = 1'b0;
        a_data_i  = 8'h00;
        a_valid_i = 1'b0;
        a_ready_i = 1'b1;
        b_data_i  = 8'h00;
        b_valid_i = 1'b0;
        b_ready_i = 1'b1;
        clear_obs();

        #12;
        check_eq("rst_valid", 32'(a_valid_o), 32'd0);
        check_eq("rst_ready", 32'(a_ready_o), 32'd1);
        check_eq("rst_last", 32'(a_last_o), 32'd0);
        check_eq("rst_unpacked", 32'(a_unpacked_o), 32'd0);
        check_eq("rst_frame_ok", 32'(a_frame_ok_o), 32'd0);
        check_eq("rst_tail_err", 32'(a_tail_err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: B4 0F gives 0,0,1,0,1,1,0,1,1,1,1,1; pad nibble dropped.
        clear_obs();
        push4(8'hB4, 8'h0F, 8'hA5, 8'h5A);
        run_a(1'b0, 0, 100);
        expect_obs("basic", 12, 32'h0000_0FB4, 32'h0000_0800, 1, 0);

        // Same frame under random backpressure.
        clear_obs();
        push4(8'hB4, 8'h0F, 8'hA5, 8'h5A);
        run_a(1'b1, 0, 400);
        expect_obs("stall", 12, 32'h0000_0FB4, 32'h0000_0800, 1, 0);

        // Payload bytes equal to the tail values are plain data.
        clear_obs();
        push4(8'hA5, 8'h0A, 8'hA5, 8'h5A);
        run_a(1'b0, 0, 100);
        expect_obs("tail_like_data", 12, 32'h0000_0AA5, 32'h0000_0800, 1, 0);

        // Bad second tail byte, junk 33 dropped, resync on A5 5A, next frame good.
        clear_obs();
        push4(8'hB4, 8'h0F, 8'hA5, 8'h77);
        push4(8'h33, 8'hA5, 8'h5A, 8'h3C);
        push4(8'h05, 8'hA5, 8'h5A, 8'h00);
        void'(src_q.pop_back());
        run_a(1'b0, 0, 200);
        expect_obs("resync_77", 24, 32'h0053_CFB4, 32'h0080_0800, 1, 1);

        // Second tail byte is A5: error, but it counts as the start of the resync pair.
        clear_obs();
        push4(8'hB4, 8'h0F, 8'hA5, 8'hA5);
        push4(8'h5A, 8'h3C, 8'h05, 8'hA5);
        src_q.push_back(8'h5A);
        run_a(1'b0, 0, 200);
        expect_obs("resync_a5", 24, 32'h0053_CFB4, 32'h0080_0800, 1, 1);

        // Asynchronous reset after five elements, then a fresh frame.
        clear_obs();
        push4(8'hB4, 8'h0F, 8'hA5, 8'h5A);
        run_a(1'b0, 5, 100);
        check_eq("pre_rst_valid", 32'(a_valid_o), 32'd1);
        src_q.delete();
        a_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(a_valid_o), 32'd0);
        check_eq("mid_rst_ready", 32'(a_ready_o), 32'd1);
        check_eq("mid_rst_last", 32'(a_last_o), 32'd0);
        check_eq("mid_rst_unpacked", 32'(a_unpacked_o), 32'd0);
        check_eq("mid_rst_frame_ok", 32'(a_frame_ok_o), 32'd0);
        check_eq("mid_rst_tail_err", 32'(a_tail_err_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        push4(8'h3C, 8'h05, 8'hA5, 8'h5A);
        run_a(1'b0, 0, 100);
        expect_obs("after_rst", 12, 32'h0000_053C, 32'h0000_0800, 1, 0);

        // Byte-wide instance: one element per cycle, ready_o never drops.
        b_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};
        b_n = 0; b_first = -1; b_lastcyc = -1; b_stall = 0; b_ok = 0; b_err = 0;
        b_elems = 32'h0;
        b_lasts = 4'h0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            b_ready_i = 1'b1;
            if (b_q.size() > 0) begin
                b_valid_i = 1'b1;
                b_data_i  = b_q[0];
            end else begin
                b_valid_i = 1'b0;
                b_data_i  = 8'h00;
            end
            #1;
            if (b_valid_i && !b_ready_o) b_stall++;
            if (b_frame_ok_o) b_ok++;
            if (b_tail_err_o) b_err++;
            if (b_valid_o && b_ready_i && b_n < 4) begin
                if (b_n == 0) b_first = cyc;
                b_lastcyc          = cyc;
                b_elems[b_n*8 +: 8] = b_unpacked_o;
                b_lasts[b_n]       = b_last_o;
                b_n++;
            end
            if (b_valid_i && b_ready_o) void'(b_q.pop_front());
        end
        check_eq("b_count", 32'(b_n), 32'd4);
        check_eq("b_elems", b_elems, 32'h4433_2211);
        check_eq("b_last", 32'(b_lasts), 32'h8);
        check_eq("b_span", 32'(b_lastcyc - b_first), 32'd3);
        check_eq("b_ready_drops", 32'(b_stall), 32'd0);
        check_eq("b_frame_ok", 32'(b_ok), 32'd1);
        check_eq("b_tail_err", 32'(b_err), 32'd0);
        check_eq("b_drained", 32'(b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tail_deframer.md
Name: tail_deframer

Overview:
- Receive-side counterpart of the framer. Accepts the framer's AXIS-style byte stream: fixed-length packed payload followed by tail bytes TailByte0 and TailByte1.
- Unpacks the payload into per-element UnpackedWidth beats, checks the tail, and resynchronises on tail errors.
- Sits after uart + skid_buffer on a board or bench consuming processed frames (FPGA-to-FPGA chaining, loopback self-check).

Parameters:
- UnpackedWidth, 1: bits per element.
- PackedNum, 8: elements per byte; UnpackedWidth*PackedNum must equal 8.
- PacketLenElems, 75684: elements per frame (318*238).
- TailByte0, 8'hA5: first tail byte.
- TailByte1, 8'h5A: second tail byte.
- localparam PacketBytes = ceil(PacketLenElems/PackedNum).
- localparam LastElems = PacketLenElems - (PacketBytes-1)*PackedNum.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- data_i  in  8  packed byte from skid_buffer.
- valid_i  in  1  byte valid.
- ready_o  out  1  byte accepted when valid_i&&ready_o.
- unpacked_o  out  UnpackedWidth  current element.
- valid_o  out  1  element valid.
- ready_i  in  1  downstream ready.
- last_o  out  1  high with the final element of a frame.
- frame_ok_o  out  1  1-cycle pulse: TailByte1 matched.
- tail_err_o  out  1  1-cycle pulse: tail mismatch detected.

Behaviour:
- Reset (async assert, sync deassert) values:
  - state=PAYLOAD; byte/element counters=0; hold register empty.
  - valid_o=0, ready_o=1, last_o=0, frame_ok_o=0, tail_err_o=0, unpacked_o=0.
- The first frame has no header. The block starts directly in PAYLOAD.
- States:
  - PAYLOAD: hold register (8b) plus element index.
    - ready_o = !hold_valid || (valid_o && ready_i && element is the last valid one of this byte). ready_o depends combinationally on ready_i; this is a documented exception.
    - Accepted byte → hold_valid=1 next cycle. Element 0 appears on unpacked_o one cycle after acceptance (latency 1).
    - Element e = bits [e*UnpackedWidth +: UnpackedWidth], LSB first.
    - Each beat with valid_o&&ready_i advances the element index. Refilling in the same cycle allows back-to-back bytes with no bubble.
    - Final byte (byte counter == PacketBytes-1): only LastElems elements are emitted. Pad bits are discarded, never checked.
    - last_o = valid_o on the final element. After it is consumed, go to TAIL0; the byte counter wraps to 0.
    - valid_o stays high and unpacked_o stays stable while ready_i=0.
  - TAIL0 (ready_o=1, valid_o=0):
    - byte==TailByte0 → TAIL1.
    - else pulse tail_err_o, go to RESYNC with seen=0.
  - TAIL1 (ready_o=1):
    - byte==TailByte1 → pulse frame_ok_o, go to PAYLOAD.
    - else pulse tail_err_o, go to RESYNC with seen=(byte==TailByte0).
  - RESYNC (ready_o=1, bytes dropped):
    - byte==TailByte0 → seen=1.
    - byte==TailByte1 && seen → PAYLOAD.
    - otherwise seen=0.
- Pulses are registered and fire the cycle after the deciding byte is accepted.
- Payload bytes equal to A5/5A are data. The tail is only checked in TAIL0/TAIL1.
- No byte is accepted while a payload element is still pending, except the same-cycle refill case.
- Reset mid-frame: all state is discarded and the block returns to PAYLOAD with counters at 0. Any partial element is lost, with no pulse.

Decomposition:
- Shared package framing_pkg holds:
  - state enum tail_deframer_state_e {PAYLOAD, TAIL0, TAIL1, RESYNC};
  - default tail constants 8'hA5/8'h5A, shared with framer;
  - a ceil-div function for PacketBytes.
- One natural sub-module: byte_unpacker (hold register, element index, PAYLOAD handshake). The FSM and counters stay in tail_deframer.

Test Plan (PacketLenElems=12, PackedNum=8, UnpackedWidth=1 unless noted):
- Bytes 8'hB4, 8'h0F, A5, 5A with ready_i=1 → 12 elements 0,0,1,0,1,1,0,1,1,1,1,1; last_o on element 11; frame_ok_o pulse; pad nibble 0x0 not emitted.
- Same frame with ready_i toggled randomly at 50% → identical element sequence; unpacked_o stable while stalled; no byte lost.
- Tail bytes A5, 77, then 33, A5, 5A, then the next frame → tail_err_o once; 33 dropped; next frame decoded correctly with frame_ok_o.
- Tail bytes A5, A5, 5A → tail_err_o, then resync on the trailing A5 5A; next payload accepted.
- PackedNum=1, UnpackedWidth=8, PacketLenElems=4, bytes streamed every cycle with ready_i=1 → one element per cycle, ready_o never deasserts in PAYLOAD.
- rst_ni low asynchronously after 5 elements → outputs return to reset values immediately; a fresh full frame after release decodes correctly.
